spi_burst_sequencer: RTL

//  Upstream feeder/collector for the SPI master. Buffers host TX bytes in a FIFO and launches one

---
 rtl/spi_burst_sequencer.sv | 201 ++++++++++++++++++++
 1 files changed

// File: rtl/spi_burst_sequencer.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : spi_burst_sequencer                                        |
// | Description : Feeds buffered host TX bytes to the SPI master one burst   |
// |               of BYTE_COUNT bytes per start request, and collects the    |
// |               received bytes into an RX FIFO for the host.               |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module spi_burst_sequencer #(
   parameter int BYTE_COUNT = 5,
   parameter int TX_DEPTH   = 16,
   parameter int RX_DEPTH   = 16
) (
   input  logic       i_clk,
   input  logic       i_rst_n,
   input  logic       i_tx_valid,
   output logic       o_tx_ready,
   input  logic [7:0] i_tx_data,
   output logic       o_rx_valid,
   input  logic       i_rx_ready,
   output logic [7:0] o_rx_data,
   input  logic       i_start,
   output logic       o_busy,
   output logic       o_xfer_done,
   output logic       o_TX_DV,
   output logic [7:0] o_TX_DATA,
   input  logic       i_done,
   input  logic       i_bytedone,
   input  logic [7:0] i_RX_DATA
);

   localparam int TXAW = $clog2(TX_DEPTH);
   localparam int RXAW = $clog2(RX_DEPTH);
   localparam int CW   = $clog2(BYTE_COUNT + 1);

   localparam logic [2:0] c_st_idle     = 3'd0;
   localparam logic [2:0] c_st_load     = 3'd1;
   localparam logic [2:0] c_st_launch   = 3'd2;
   localparam logic [2:0] c_st_xfer     = 3'd3;
   localparam logic [2:0] c_st_complete = 3'd4;

   localparam logic [CW-1:0]   c_byte_count = CW'(BYTE_COUNT);
   localparam logic [CW-1:0]   c_last_rcvd  = CW'(BYTE_COUNT - 1);
   localparam logic [TXAW:0]   c_tx_depth   = (TXAW + 1)'(TX_DEPTH);
   localparam logic [TXAW:0]   c_tx_need    = (TXAW + 1)'(BYTE_COUNT);
   localparam logic [RXAW:0]   c_rx_depth   = (RXAW + 1)'(RX_DEPTH);
   localparam logic [RXAW:0]   c_rx_need    = (RXAW + 1)'(BYTE_COUNT);

   logic [2:0]      r_state;
   logic [2:0]      w_next_state;

   logic [7:0]      r_tx_mem [TX_DEPTH];
   logic [TXAW-1:0] r_tx_wp;
   logic [TXAW-1:0] r_tx_rp;
   logic [TXAW:0]   r_tx_count;
   logic [7:0]      r_rx_mem [RX_DEPTH];
   logic [RXAW-1:0] r_rx_wp;
   logic [RXAW-1:0] r_rx_rp;
   logic [RXAW:0]   r_rx_count;

   logic [CW-1:0]   r_sent;
   logic [CW-1:0]   r_rcvd;
   logic            r_bd_d;
   logic [7:0]      r_tx_data;

   logic            w_tx_pop_req;
   logic            w_rx_push_req;
   logic            w_tx_full;
   logic            w_tx_empty;
   logic            w_rx_full;
   logic            w_rx_empty;
   logic            w_tx_push;
   logic            w_tx_pop;
   logic            w_rx_push;
   logic            w_rx_pop;
   logic [RXAW:0]   w_rx_free;
   logic            w_can_start;

   assign w_tx_full   = (r_tx_count == c_tx_depth);
   assign w_tx_empty  = (r_tx_count == '0);
   assign w_rx_full   = (r_rx_count == c_rx_depth);
   assign w_rx_empty  = (r_rx_count == '0);

   // A pop frees the slot the simultaneous push lands in, so a full FIFO still accepts it
   assign w_tx_pop    = w_tx_pop_req && !w_tx_empty;
   assign w_tx_push   = i_tx_valid && (!w_tx_full || w_tx_pop);
   assign w_rx_pop    = i_rx_ready && !w_rx_empty;
   assign w_rx_push   = w_rx_push_req && (!w_rx_full || w_rx_pop);

   assign w_rx_free   = c_rx_depth - r_rx_count;
   assign w_can_start = (r_tx_count >= c_tx_need) && (w_rx_free >= c_rx_need);

   assign o_tx_ready  = !w_tx_full;
   assign o_rx_valid  = !w_rx_empty;
   assign o_rx_data   = r_rx_mem[r_rx_rp];
   assign o_TX_DATA   = r_tx_data;

   // State register
   always_ff @(posedge i_clk) begin
      if (!i_rst_n) r_state <= c_st_idle;
      else          r_state <= w_next_state;
   end

   // Next state: only start a burst that can neither underflow TX nor overflow RX
   always_comb begin
      w_next_state = r_state;
      case (r_state)
         c_st_idle:     if (i_start && w_can_start) w_next_state = c_st_load;
         c_st_load:     w_next_state = c_st_launch;
         c_st_launch:   w_next_state = c_st_xfer;
         c_st_xfer:     if (r_bd_d && (r_rcvd == c_last_rcvd)) w_next_state = c_st_complete;
         c_st_complete: w_next_state = c_st_idle;
         default:       w_next_state = c_st_idle;
      endcase
   end

   // State-decoded outputs and FIFO requests
   always_comb begin
      o_TX_DV       = 1'b0;
      o_busy        = (r_state != c_st_idle);
      o_xfer_done   = 1'b0;
      w_tx_pop_req  = 1'b0;
      w_rx_push_req = 1'b0;
      case (r_state)
         c_st_load:     w_tx_pop_req = 1'b1;
         c_st_launch:   o_TX_DV = 1'b1;
         c_st_xfer: begin
            w_tx_pop_req  = i_done && (r_sent < c_byte_count);
            w_rx_push_req = r_bd_d;
         end
         c_st_complete: o_xfer_done = 1'b1;
         default: ;
      endcase
   end

   // Burst bookkeeping; the next byte is loaded ahead of the master's byte boundary
   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         r_tx_data <= '0;
         r_sent    <= '0;
         r_rcvd    <= '0;
         r_bd_d    <= 1'b0;
      end else begin
         r_bd_d <= i_bytedone;
         if (w_tx_pop_req) r_tx_data <= r_tx_mem[r_tx_rp];
         if (r_state == c_st_load) begin
            r_sent <= CW'(1);
            r_rcvd <= '0;
         end else begin
            if (w_tx_pop_req)  r_sent <= r_sent + CW'(1);
            if (w_rx_push_req) r_rcvd <= r_rcvd + CW'(1);
         end
      end
   end

   // TX FIFO pointers and occupancy
   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         r_tx_wp    <= '0;
         r_tx_rp    <= '0;
         r_tx_count <= '0;
      end else begin
         if (w_tx_push) r_tx_wp <= r_tx_wp + TXAW'(1);
         if (w_tx_pop)  r_tx_rp <= r_tx_rp + TXAW'(1);
         case ({w_tx_push, w_tx_pop})
            2'b10:   r_tx_count <= r_tx_count + (TXAW + 1)'(1);
            2'b01:   r_tx_count <= r_tx_count - (TXAW + 1)'(1);
            default: ;
         endcase
      end
   end

   // TX FIFO storage
   always_ff @(posedge i_clk) begin
      if (w_tx_push) r_tx_mem[r_tx_wp] <= i_tx_data;
   end

   // RX FIFO pointers and occupancy
   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         r_rx_wp    <= '0;
         r_rx_rp    <= '0;
         r_rx_count <= '0;
      end else begin
         if (w_rx_push) r_rx_wp <= r_rx_wp + RXAW'(1);
         if (w_rx_pop)  r_rx_rp <= r_rx_rp + RXAW'(1);
         case ({w_rx_push, w_rx_pop})
            2'b10:   r_rx_count <= r_rx_count + (RXAW + 1)'(1);
            2'b01:   r_rx_count <= r_rx_count - (RXAW + 1)'(1);
            default: ;
         endcase
      end
   end

   // RX FIFO storage
   always_ff @(posedge i_clk) begin
      if (w_rx_push) r_rx_mem[r_rx_wp] <= i_RX_DATA;
   end

endmodule
`default_nettype wire
